// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: turns SSEL-framed SPI byte streams (command byte + data burst) into register-bank reads/writes.
// Latency: wr_en/rd_en 1 cycle after rx_valid; tx_load 2 cycles after rx_valid in READ, 1 cycle after frame_start.
// Backpressure: none; the byte stream cannot stall, so READ relies on rx_valid arriving at least 3 cycles apart.
// Optional: define SPI_CMD_STATS_EN to add the frame_cnt / err_cnt statistics outputs.
module spi_cmd_decoder #(
    parameter int ADDR_W   = 7,
    parameter int NUM_REGS = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              frame_end,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              tx_load,
    output logic [7:0]        tx_byte,
    output logic              cmd_err
`ifdef SPI_CMD_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [7:0]        err_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    // Highest legal address; the address counter wraps from here back to 0.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic [7:0]        NUM_B     = 8'(NUM_REGS);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                tx_load_q, tx_load_d;
    // tx_sel_q: the byte being loaded this cycle comes straight from rd_data.
    logic                tx_sel_q, tx_sel_d;
    logic [7:0]          tx_hold_q, tx_hold_d;
    logic                cmd_err_q, cmd_err_d;

    logic [ADDR_W-1:0]   cmd_addr;
    logic                cmd_bad;

    // The full 7-bit field is compared, so bits above ADDR_W being set also flag an error.
    assign cmd_addr = rx_byte[ADDR_W-1:0];
    assign cmd_bad  = ({1'b0, rx_byte[6:0]} >= NUM_B);

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
    endfunction

    // Frame FSM, strobe scheduling and address sequencing.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        // A read issued last cycle always completes, even after frame_end.
        tx_load_d = rd_en_q;
        tx_sel_d  = rd_en_q;
        tx_hold_d = tx_sel_q ? rd_data : tx_hold_q;
        cmd_err_d = 1'b0;

        if (frame_start) begin
            // A new frame wins over any byte in the same cycle.
            cmd_err_d = (state_q != IDLE);
            state_d   = CMD;
            tx_load_d = 1'b1;
            tx_sel_d  = 1'b0;
            tx_hold_d = 8'h00;
        end else begin
            if (rx_valid) begin
                case (state_q)
                    CMD: begin
                        if (cmd_bad) begin
                            cmd_err_d = 1'b1;
                            state_d   = DRAIN;
                        end else if (rx_byte[7]) begin
                            addr_d  = cmd_addr;
                            state_d = WRITE;
                        end else begin
                            rd_en_d   = 1'b1;
                            rd_addr_d = cmd_addr;
                            addr_d    = next_addr(cmd_addr);
                            state_d   = READ;
                        end
                    end
                    WRITE: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = rx_byte;
                        addr_d    = next_addr(addr_q);
                    end
                    READ: begin
                        rd_en_d   = 1'b1;
                        rd_addr_d = addr_q;
                        addr_d    = next_addr(addr_q);
                    end
                    default: ;
                endcase
            end
            // Byte in the same cycle is handled above first, then the frame closes.
            if (frame_end) begin
                state_d = IDLE;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'h00;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            tx_load_q <= 1'b0;
            tx_sel_q  <= 1'b0;
            tx_hold_q <= 8'h00;
            cmd_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            tx_load_q <= tx_load_d;
            tx_sel_q  <= tx_sel_d;
            tx_hold_q <= tx_hold_d;
            cmd_err_q <= cmd_err_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign tx_load = tx_load_q;
    // Read data is valid only in the load cycle, so it is passed through then and held afterwards.
    assign tx_byte = tx_sel_q ? rd_data : tx_hold_q;
    assign cmd_err = cmd_err_q;

`ifdef SPI_CMD_STATS_EN
    logic        frame_done;
    logic [15:0] frame_cnt_q;
    logic [7:0]  err_cnt_q;

    // A frame counts once its command byte was accepted (including a command byte arriving with frame_end).
    assign frame_done = frame_end && !frame_start &&
                        ((state_q == WRITE) || (state_q == READ) ||
                         ((state_q == CMD) && rx_valid && !cmd_bad));

    // Statistics counters; the error counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= 16'd0;
            err_cnt_q   <= 8'd0;
        end else begin
            if (frame_done) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            if (cmd_err_d && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule
